imem_responder: RTL and testbench

- Instruction-memory responder: the memory end of the CPU instruction-fetch interface.
- Accepts word-address fetch requests over a valid/ready handshake, inserts a programmable number of wait states, and returns the instruction word over a valid/ready response channel.
- A side load port writes program words, used by the bench and boot loader.
- Replaces the zero-latency instruction memory when the CPU moves to a stalling fetch stage.

---
 rtl/mips32_mem_pkg.sv | 17 +
 rtl/imem_array.sv | 44 ++++
 rtl/imem_responder.sv | 111 +++++++++++
 tb/tb_imem_responder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_mem_pkg.sv
// mips32_mem_pkg
// Shared types and widths for the MIPS32 memory-side blocks.
//   state_t     : responder FSM state encoding (IDLE / WAIT / RESP)
//   INSTR_W     : instruction word width
//   WORD_ADDR_W : width of a word address (PC[31:2])
package mips32_mem_pkg;

  localparam int INSTR_W     = 32;
  localparam int WORD_ADDR_W = 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/imem_array.sv
// imem_array
// Synchronous single-write / single-read word RAM for instruction storage.
// Ports:
//   clk, reset : clock and synchronous active-low reset (clears rdata only)
//   we, waddr, wdata : write port, one word per cycle
//   re, raddr  : read enable and address; rdata is registered and holds
//                its value while re is low
//   rdata      : read word; on a same-cycle write to raddr the new word
//                is returned (write-first)
module imem_array
  import mips32_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [0:(2**ADDR_W)-1];

  // Storage is never cleared, so it carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Write-first bypass: a write landing on the same edge as the read
  // must be visible in the returned word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder
// Memory end of the CPU instruction-fetch interface. A request accepted
// in IDLE waits WAIT_STATES cycles, then the word is read and offered on
// the response channel until the fetch stage takes it.
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   req_valid/req_ready  : request handshake, req_addr is a word address
//   resp_valid/resp_ready: response handshake carrying resp_data/resp_err
//   resp_err             : address beyond the implemented depth (data = 0)
//   load_en/addr/data    : side write port, usable in any state
//   fetch_count          : completed response handshakes (wrapping)
module imem_responder
  import mips32_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WORD_ADDR_W-1:0] req_addr,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [INSTR_W-1:0]     resp_data,
  output logic                   resp_err,
  input  logic                   load_en,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [INSTR_W-1:0]     load_data,
  output logic [31:0]            fetch_count
);

  // The counter is loaded with WAIT_STATES and the read happens on the
  // edge that finds it at zero, so the response appears WAIT_STATES+1
  // edges after acceptance (one edge when WAIT_STATES is zero).
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  state_t                 state, state_nxt;
  logic [3:0]             cnt;
  logic [WORD_ADDR_W-1:0] addr_q;
  logic                   accept, read_fire, resp_fire;
  logic                   out_of_range, ram_we;
  logic [INSTR_W-1:0]     ram_rdata;

  assign req_ready    = (state == ST_IDLE);
  assign accept       = req_valid && req_ready;
  assign read_fire    = (state == ST_WAIT) && (cnt == 4'd0);
  assign resp_fire    = resp_valid && resp_ready;
  assign out_of_range = |addr_q[WORD_ADDR_W-1:ADDR_W];
  assign ram_we       = load_en && reset;

  // An out-of-range fetch reports zero data whatever the RAM returned.
  assign resp_data = resp_err ? '0 : ram_rdata;

  imem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (read_fire),
    .raddr (addr_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_WAIT;
      ST_WAIT: if (read_fire) state_nxt = ST_RESP;
      ST_RESP: if (resp_fire) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Captured address, wait counter, response flags and fetch counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q      <= '0;
      cnt         <= 4'd0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        cnt    <= CNT_INIT;
      end
      if ((state == ST_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (read_fire) begin
        resp_valid <= 1'b1;
        resp_err   <= out_of_range;
      end
      if (resp_fire) begin
        resp_valid  <= 1'b0;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int ADDR_W = 10;
  localparam int WS     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, load_en;
  logic [29:0] req_addr;
  logic [31:0] resp_data, load_data, fetch_count;
  logic [9:0]  load_addr;

  logic        req_valid_z, req_ready_z, resp_valid_z, resp_ready_z, resp_err_z, load_en_z;
  logic [29:0] req_addr_z;
  logic [31:0] resp_data_z, load_data_z, fetch_count_z;
  logic [9:0]  load_addr_z;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] model_mem [0:1023];
  logic [31:0] model_count   = 0;
  logic [31:0] model_count_z = 0;

  imem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .fetch_count(fetch_count)
  );

  imem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_addr(req_addr_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z), .resp_data(resp_data_z),
    .resp_err(resp_err_z), .load_en(load_en_z), .load_addr(load_addr_z),
    .load_data(load_data_z), .fetch_count(fetch_count_z)
  );

  // Writes one word through the load port and mirrors it in the model.
  task automatic load_word(input logic [9:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Issues one fetch. A load (ld_n > 0) is driven at the ld_n-th falling
  // edge after the request was presented; the response is then held for
  // 'hold' cycles before being taken. Returns the latency in edges after
  // acceptance and the word/error seen just before the handshake.
  task automatic run_fetch(input logic [29:0] addr, input int ld_n,
                           input logic [9:0] ld_a, input logic [31:0] ld_d,
                           input int hold, output int lat,
                           output logic [31:0] d, output logic e);
    int n;
    req_valid = 1'b1; req_addr = addr; resp_ready = 1'b0;
    load_addr = ld_a; load_data = ld_d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      req_valid = 1'b0;
      load_en   = (n == ld_n);
    end while (!resp_valid && n < 40);
    lat = n - 1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n++;
      load_en = (n == ld_n);
    end
    d = resp_data; e = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0; load_en = 1'b0;
    if (ld_n > 0) model_mem[ld_a] = ld_d;
    model_count = model_count + 1;
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b1; req_addr = 30'd5;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'd0 || fetch_count !== 32'd0) begin
        fails++;
        $display("[TB] FAIL reset_state: ready=%b valid=%b data=%h count=%0d expected 1 0 0 0",
                 req_ready, resp_valid, resp_data, fetch_count);
      end
    end
    checks++;
    if (req_ready_z !== 1'b1 || resp_valid_z !== 1'b0 || fetch_count_z !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_state_z: ready=%b valid=%b count=%0d expected 1 0 0",
               req_ready_z, resp_valid_z, fetch_count_z);
    end
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_no_accept: req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_basic;
    int lat; logic [31:0] d; logic e;
    load_word(10'd3, 32'h20080005);
    run_fetch(30'd3, 0, 10'd0, 32'd0, 0, lat, d, e);
    checks++;
    if (lat != WS + 1) begin
      fails++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, WS + 1);
    end
    checks++;
    if (d !== 32'h20080005 || e !== 1'b0) begin
      fails++; $display("[TB] FAIL basic_data: got %h err=%b expected 20080005 err=0", d, e);
    end
    checks++;
    if (fetch_count !== 32'd1) begin
      fails++; $display("[TB] FAIL basic_count: got %0d expected 1", fetch_count);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] w, held; logic held_err; int n;
    w = $urandom;
    load_word(10'd17, w);
    req_valid = 1'b1; req_addr = 30'd17; resp_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++; req_valid = 1'b0;
    end while (!resp_valid && n < 40);
    held = resp_data; held_err = resp_err;
    checks++;
    if (held !== w || held_err !== 1'b0) begin
      fails++; $display("[TB] FAIL bp_data: got %h err=%b expected %h err=0", held, held_err, w);
    end
    for (int c = 0; c < 5; c++) begin
      // A write to the same word while the response is held must not leak in.
      load_en = (c == 1); load_addr = 10'd17; load_data = ~w;
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== w || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL bp_hold: valid=%b data=%h err=%b ready=%b expected 1 %h 0 0",
                 resp_valid, resp_data, resp_err, req_ready, w);
      end
    end
    load_en = 1'b0; model_mem[10'd17] = ~w;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    model_count = model_count + 1;
    checks++;
    if (resp_valid !== 1'b0 || fetch_count !== model_count || req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bp_release: valid=%b count=%0d ready=%b expected 0 %0d 1",
               resp_valid, fetch_count, req_ready, model_count);
    end
  endtask

  task automatic test_out_of_range;
    int lat; logic [31:0] d; logic e;
    load_word(10'd0, 32'hCAFEF00D);
    run_fetch(30'h400, 0, 10'd0, 32'd0, 0, lat, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'd0) begin
      fails++; $display("[TB] FAIL oor_0x400: got %h err=%b expected 00000000 err=1", d, e);
    end
    load_word(10'h3FF, 32'h0BADC0DE);
    run_fetch(30'h3FF, 0, 10'd0, 32'd0, 0, lat, d, e);
    checks++;
    if (e !== 1'b0 || d !== 32'h0BADC0DE) begin
      fails++; $display("[TB] FAIL oor_top_word: got %h err=%b expected 0badc0de err=0", d, e);
    end
  endtask

  task automatic test_collision;
    int lat; logic [31:0] d; logic e;
    load_word(10'd7, 32'h11111111);
    run_fetch(30'd7, WS + 1, 10'd7, 32'hDEADBEEF, 0, lat, d, e);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      fails++; $display("[TB] FAIL collision_read_edge: got %h expected deadbeef", d);
    end
    load_word(10'd7, 32'h11111111);
    run_fetch(30'd7, WS + 2, 10'd7, 32'hDEADBEEF, 1, lat, d, e);
    checks++;
    if (d !== 32'h11111111) begin
      fails++; $display("[TB] FAIL collision_after_read: got %h expected 11111111", d);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w; int hs;
    w = $urandom;
    load_word(10'd21, w);
    req_valid = 1'b1; req_addr = 30'd21; resp_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 5 * (WS + 3); c++) begin
      if (resp_valid && resp_ready) begin
        hs++;
        checks++;
        if (resp_data !== w) begin
          fails++; $display("[TB] FAIL b2b_data: got %h expected %h", resp_data, w);
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    model_count = model_count + 32'(hs);
    checks++;
    if (hs != 5) begin
      fails++; $display("[TB] FAIL b2b_throughput: got %0d handshakes expected 5", hs);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (fetch_count !== model_count || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_count: count=%0d valid=%b ready=%b expected %0d 0 1",
               fetch_count, resp_valid, req_ready, model_count);
    end
  endtask

  task automatic test_random;
    logic [29:0] addr; logic [9:0] ld_a; logic [31:0] ld_d, exp_d, d;
    logic exp_e, e; int ld_n, hold, lat;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 3) == 0) addr = {20'($urandom_range(1, 20'hFFFFF)), 10'($urandom)};
      else                           addr = {20'd0, 10'($urandom)};
      load_word(addr[9:0], $urandom);
      ld_n = $urandom_range(0, WS + 2);
      ld_a = ($urandom_range(0, 1) == 1) ? addr[9:0] : 10'($urandom);
      ld_d = $urandom;
      hold = $urandom_range(0, 3);
      exp_e = (addr[29:10] != 20'd0);
      if (exp_e)                                                    exp_d = 32'd0;
      else if (ld_n >= 1 && ld_n <= WS + 1 && ld_a == addr[9:0])    exp_d = ld_d;
      else                                                          exp_d = model_mem[addr[9:0]];
      run_fetch(addr, ld_n, ld_a, ld_d, hold, lat, d, e);
      checks++;
      if (lat != WS + 1 || d !== exp_d || e !== exp_e || fetch_count !== model_count) begin
        fails++;
        $display("[TB] FAIL random_%0d: addr=%h lat=%0d data=%h err=%b count=%0d expected lat=%0d data=%h err=%b count=%0d",
                 it, addr, lat, d, e, fetch_count, WS + 1, exp_d, exp_e, model_count);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] old, d; logic e;
    old = $urandom;
    load_word(10'd9, old);
    req_valid = 1'b1; req_addr = 30'd9;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; load_en = 1'b1; load_addr = 10'd9; load_data = ~old;
    @(negedge clk);
    reset = 1'b1; load_en = 1'b0;
    model_count = 0; model_count_z = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || fetch_count !== 32'd0) begin
        fails++;
        $display("[TB] FAIL reset_mid: valid=%b ready=%b count=%0d expected 0 1 0",
                 resp_valid, req_ready, fetch_count);
      end
    end
    run_fetch(30'd9, 0, 10'd0, 32'd0, 0, lat, d, e);
    checks++;
    if (d !== old) begin
      fails++; $display("[TB] FAIL load_in_reset: got %h expected %h", d, old);
    end
  endtask

  task automatic test_zero_wait;
    logic [31:0] w; int n;
    w = $urandom;
    load_en_z = 1'b1; load_addr_z = 10'd0; load_data_z = w;
    @(negedge clk);
    load_en_z = 1'b0;
    req_valid_z = 1'b1; req_addr_z = 30'd0; resp_ready_z = 1'b0;
    @(negedge clk);
    req_valid_z = 1'b0;
    n = 0;
    while (!resp_valid_z && n < 40) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n != 1 || resp_data_z !== w || resp_err_z !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_wait: lat=%0d data=%h err=%b expected 1 %h 0", n, resp_data_z, resp_err_z, w);
    end
    resp_ready_z = 1'b1;
    @(negedge clk);
    resp_ready_z = 1'b0;
    model_count_z = model_count_z + 1;
    checks++;
    if (fetch_count_z !== model_count_z || resp_valid_z !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_wait_count: count=%0d valid=%b expected %0d 0",
               fetch_count_z, resp_valid_z, model_count_z);
    end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    req_valid_z = 1'b0; req_addr_z = '0; resp_ready_z = 1'b0;
    load_en_z = 1'b0; load_addr_z = '0; load_data_z = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_out_of_range();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_zero_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
